sc_stream_decoder: RTL

// Stochastic-to-binary decoder: the reader at the output end of the SC datapath (e.g. divider quotient).

---
 rtl/sc_pkg.sv | 13 +
 rtl/sc_ones_counter.sv | 27 ++
 rtl/sc_stream_decoder.sv | 108 ++++++++++
 3 files changed

// File: rtl/sc_pkg.sv
// Shared types and helpers for the stochastic-computing stream decoder.
package sc_pkg;

  typedef enum logic [1:0] {SC_IDLE, SC_COUNT, SC_DONE} sc_dec_state_t;

  // Clamp x to the largest value representable in w bits.
  function automatic logic [31:0] sc_sat(input logic [31:0] x, input int unsigned w);
    logic [31:0] lim;
    lim = (32'd1 << w) - 32'd1;
    return (x > lim) ? lim : x;
  endfunction

endpackage

// File: rtl/sc_ones_counter.sv
// Up-counter with synchronous clear and a qualified increment of 0 or 1.
module sc_ones_counter #(
  parameter int W = 9
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         clr_i,
  input  logic         en_i,
  input  logic         inc_i,
  output logic [W-1:0] cnt_o
);

  logic [W-1:0] cnt_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt_q <= '0;
    end else if (clr_i) begin
      cnt_q <= '0;
    end else if (en_i) begin
      cnt_q <= cnt_q + W'(inc_i);
    end
  end

  assign cnt_o = cnt_q;

endmodule

// File: rtl/sc_stream_decoder.sv
// Stochastic-to-binary decoder: counts ones over 2**WIDTH qualified bits, result via valid/ready.
// Optional live ones-count port enabled by defining SC_DEC_PARTIAL_EN.
module sc_stream_decoder
  import sc_pkg::*;
#(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic             inStream,
  input  logic             inValid,
  output logic             busy,
  output logic             outValid,
  input  logic             outReady,
`ifdef SC_DEC_PARTIAL_EN
  output logic [WIDTH:0]   partialOut,
`endif
  output logic [WIDTH-1:0] outData
);

  localparam logic [WIDTH:0] LAST_IDX = {1'b0, {WIDTH{1'b1}}};

  sc_dec_state_t    state_q;
  logic             busy_q;
  logic             out_valid_q;
  logic [WIDTH-1:0] out_data_q;
  logic [WIDTH:0]   bit_cnt;
  logic [WIDTH:0]   ones_cnt;
  logic             accept_start;
  logic             cnt_en;
  logic             last_bit;

  // A start is taken from IDLE, or from DONE only when the result is handed off that cycle.
  assign accept_start = start & ((state_q == SC_IDLE) | ((state_q == SC_DONE) & outReady));
  assign cnt_en       = (state_q == SC_COUNT) & inValid;
  assign last_bit     = cnt_en & (bit_cnt == LAST_IDX);

  sc_ones_counter #(.W(WIDTH + 1)) u_bit_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept_start),
    .en_i  (cnt_en),
    .inc_i (1'b1),
    .cnt_o (bit_cnt)
  );

  sc_ones_counter #(.W(WIDTH + 1)) u_ones_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .clr_i (accept_start),
    .en_i  (cnt_en),
    .inc_i (inStream),
    .cnt_o (ones_cnt)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= SC_IDLE;
      busy_q      <= 1'b0;
      out_valid_q <= 1'b0;
      out_data_q  <= '0;
    end else begin
      case (state_q)
        SC_IDLE: begin
          if (start) begin
            state_q <= SC_COUNT;
            busy_q  <= 1'b1;
          end
        end
        SC_COUNT: begin
          if (last_bit) begin
            state_q     <= SC_DONE;
            busy_q      <= 1'b0;
            out_valid_q <= 1'b1;
            // The final bit is folded in here since the counter only sees it on this same edge.
            out_data_q  <= WIDTH'(sc_sat(32'(ones_cnt) + 32'(inStream), WIDTH));
          end
        end
        SC_DONE: begin
          if (outReady) begin
            out_valid_q <= 1'b0;
            if (start) begin
              state_q <= SC_COUNT;
              busy_q  <= 1'b1;
            end else begin
              state_q <= SC_IDLE;
            end
          end
        end
        default: begin
          state_q     <= SC_IDLE;
          busy_q      <= 1'b0;
          out_valid_q <= 1'b0;
        end
      endcase
    end
  end

  assign busy     = busy_q;
  assign outValid = out_valid_q;
  assign outData  = out_data_q;

`ifdef SC_DEC_PARTIAL_EN
  assign partialOut = ones_cnt;
`endif

endmodule
